queue_counter: RTL and testbench
================================

# queue_counter

Upstream stage of the bank-queue wait-time lookup. Converts the raw arrival (front) and departure (rear) door sensors into a debounced, saturating customer count. Produces the 5-bit lookup index {tcount, pcount} plus empty/full flags consumed directly by the wait-time ROM. Also flags rejected events (arrival when full, departure when empty) for the display/alarm logic.

## Interface
Parameters:
- DEPTH, 7: maximum queue occupancy; legal range 1..7 (pcount is 3 bits).
- DEBOUNCE, 4: consecutive cycles a synchronized sensor level must hold before it is accepted; legal range 1..15.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- front_sensor  in  1  arrival sensor, asynchronous level, high = person in beam.
- rear_sensor  in  1  departure sensor, asynchronous level, high = person in beam.
- tcount  in  2  number of open tellers (quasi-static switches); 0 = none open.
- pcount  out  3  current people count, 0..DEPTH.
- ef  out  1  empty flag, pcount == 0.
- ff  out  1  full flag, pcount == DEPTH.
- index  out  5  {tcount_q, pcount}; tcount_q is tcount registered once.
- ovf_err  out  1  one-cycle pulse: arrival rejected because full.
- udf_err  out  1  one-cycle pulse: departure rejected because empty.

## Operation
- Per sensor: 2-flop synchronizer (s1, s2) -> debouncer -> rising-edge detector.
- Debouncer: holds accepted level db (reset 0) and a 4-bit stability counter. Each edge: if s2 == db, counter clears; else counter increments, and when s2 has differed from db on DEBOUNCE consecutive edges, db takes s2 and counter clears. Any return to db before that clears the counter (glitch rejected).
- Event: arr = db_front & ~db_front_prev; dep = db_rear & ~db_rear_prev (prev registered, reset 0). Falling edges of db produce no event. A sensor held high continuously produces exactly one event.
- Counter update, per edge, priority in order:
  - arr and dep same cycle: pcount unchanged, no error pulse (regardless of count, including 0 and DEPTH).
  - arr only: pcount < DEPTH -> pcount+1; pcount == DEPTH -> unchanged, ovf_err = 1 next cycle.
  - dep only: pcount > 0 -> pcount-1; pcount == 0 -> unchanged, udf_err = 1 next cycle.
  - neither: unchanged; ovf_err, udf_err = 0.
- No wrap-around ever: count saturates at 0 and DEPTH.
- ef, ff decoded combinationally from the pcount register (glitch-free, follow pcount same cycle).
- tcount_q samples tcount every edge, no debouncing; index = {tcount_q, pcount}.

## Timing
- Reset (async assert, any time incl. mid-debounce): pcount 0, ef 1, ff 0, index 0, ovf_err 0, udf_err 0; synchronizers, db, db_prev, stability counters, tcount_q all 0. Pending/partial debounce is discarded.
- Sensor held high through reset release is treated as a new rising level and counts once after full latency.
- Latency: sensor first sampled high at edge k -> s2 high after k+1 -> db high after k+1+DEBOUNCE -> pcount/error update after edge k+2+DEBOUNCE (k+6 at default).
- Sensor pulse shorter than DEBOUNCE+1 sampled cycles may be rejected; pulse shorter than DEBOUNCE synchronized cycles is always rejected.
- Sensor low time must also satisfy DEBOUNCE before the next arrival is recognized.
- Error pulses assert on the same edge a legal update would have occurred; width exactly one cycle.
- tcount -> index: one edge.

## Test plan
- Reset: assert reset mid-debounce with pcount=3 -> outputs immediately pcount 0, ef 1, ff 0, index 0; after release no event from the abandoned pulse if sensor already low.
- Latency/debounce (DEBOUNCE=4): front high 10 cycles from edge k -> pcount 0->1 exactly after edge k+6; front high only 3 cycles -> pcount stays 0.
- Fill/overflow (DEPTH=7, tcount=2): 8 clean arrivals -> pcount 7, ff 1, index 5'b10111; 8th arrival gives ovf_err single-cycle pulse, pcount stays 7.
- Underflow: from pcount 1, two clean departures -> pcount 0, ef 1; second gives udf_err pulse, pcount stays 0.
- Simultaneous: at pcount 7 and at pcount 0, front and rear asserted same cycle -> pcount unchanged, no ovf_err/udf_err; at pcount 4 -> stays 4.
- Held sensor: front held high 100 cycles -> exactly one increment; tcount change 1->3 -> index MSBs update one edge later.

Source files
------------

// File: rtl/queue_counter_if.sv
// Sensor/teller inputs and count/flag outputs of the queue counter.
// The master side drives the sensors; the slave side is the counter itself.
interface queue_counter_if;
    logic       front_sensor;
    logic       rear_sensor;
    logic [1:0] tcount;
    logic [2:0] pcount;
    logic       ef;
    logic       ff;
    logic [4:0] index;
    logic       ovf_err;
    logic       udf_err;

    modport master (
        output front_sensor, rear_sensor, tcount,
        input  pcount, ef, ff, index, ovf_err, udf_err
    );

    modport slave (
        input  front_sensor, rear_sensor, tcount,
        output pcount, ef, ff, index, ovf_err, udf_err
    );
endinterface

// File: rtl/queue_counter.sv
// Debounced, saturating bank-queue occupancy counter feeding the wait-time ROM.
// Bit 0 of the per-sensor vectors is the front (arrival) sensor, bit 1 the rear.
module queue_counter #(
    parameter int unsigned DEPTH    = 7,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic            clk,
    input  logic            reset,
    queue_counter_if.slave  bus
);
    localparam logic [2:0] PMAX    = 3'(DEPTH);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    logic [1:0]       sens;
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       db_q, db_d, db_prev_q;
    logic [1:0][3:0]  stab_q, stab_d;
    logic [1:0]       ev;
    logic [2:0]       pcount_q, pcount_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [1:0]       tcount_q;

    assign sens = {bus.rear_sensor, bus.front_sensor};

    // Level is accepted on the DEBOUNCE-th consecutive differing edge.
    always_comb begin
        db_d   = db_q;
        stab_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (stab_q[i] == DB_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + 4'd1;
                end
            end
        end
    end

    assign ev = db_q & ~db_prev_q;

    always_comb begin
        pcount_d = pcount_q;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
        unique case (ev)
            2'b01: begin
                if (pcount_q == PMAX) ovf_d    = 1'b1;
                else                  pcount_d = pcount_q + 3'd1;
            end
            2'b10: begin
                if (pcount_q == '0) udf_d    = 1'b1;
                else                pcount_d = pcount_q - 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            stab_q    <= '0;
            pcount_q  <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            tcount_q  <= '0;
        end else begin
            s1_q      <= sens;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            stab_q    <= stab_d;
            pcount_q  <= pcount_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            tcount_q  <= bus.tcount;
        end
    end

    assign bus.pcount  = pcount_q;
    assign bus.ef      = (pcount_q == '0);
    assign bus.ff      = (pcount_q == PMAX);
    assign bus.index   = {tcount_q, pcount_q};
    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
endmodule

// File: tb/tb_queue_counter.sv
// Directed, table-driven bench for queue_counter at DEPTH=7, DEBOUNCE=4.
module tb_queue_counter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    queue_counter_if bus();

    queue_counter #(.DEPTH(7), .DEBOUNCE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit f;
        bit r;
        int tc;
        int p;
        int ovf;
        int udf;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    int ovf_seen = 0;
    int udf_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n edges, sampling 1ns after each and tallying error pulses.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.ovf_err) ovf_seen++;
            if (bus.udf_err) udf_seen++;
        end
    endtask

    task automatic check_outputs(input string name, input int p, input int tc);
        check({name, ".pcount"}, int'(bus.pcount), p);
        check({name, ".ef"}, int'(bus.ef), int'(p == 0));
        check({name, ".ff"}, int'(bus.ff), int'(p == 7));
        check({name, ".index"}, int'(bus.index), tc * 8 + p);
    endtask

    task automatic pulse(input bit f, input bit r, input int high, input int low);
        bus.front_sensor = f;
        bus.rear_sensor  = r;
        tick(high);
        bus.front_sensor = 1'b0;
        bus.rear_sensor  = 1'b0;
        tick(low);
    endtask

    initial begin
        reset = 1'b1;
        bus.front_sensor = 1'b0;
        bus.rear_sensor  = 1'b0;
        bus.tcount       = 2'd0;
        tick(2);
        check_outputs("reset", 0, 0);
        check("reset.ovf", int'(bus.ovf_err), 0);
        check("reset.udf", int'(bus.udf_err), 0);
        reset = 1'b0;
        tick(2);

        // First sampled edge is the tick right after raising the sensor.
        bus.front_sensor = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check($sformatf("latency.k+%0d", i), int'(bus.pcount), (i == 6) ? 1 : 0);
        end
        tick(3);
        bus.front_sensor = 1'b0;
        tick(10);

        pulse(1'b1, 1'b0, 3, 15);
        check("short_pulse", int'(bus.pcount), 1);

        bus.front_sensor = 1'b1;
        tick(100);
        check("held.high", int'(bus.pcount), 2);
        bus.front_sensor = 1'b0;
        tick(10);
        check("held.after", int'(bus.pcount), 2);

        bus.tcount = 2'd1;
        tick(2);
        check("tcount.1", int'(bus.index[4:3]), 1);
        bus.tcount = 2'd3;
        check("tcount.before_edge", int'(bus.index[4:3]), 1);
        tick(1);
        check("tcount.3", int'(bus.index[4:3]), 3);

        pulse(1'b1, 1'b0, 10, 10);
        check_outputs("pre_reset", 3, 3);

        // Async reset in the middle of a debounce window.
        bus.front_sensor = 1'b1;
        tick(3);
        #3 reset = 1'b1;
        #1;
        check_outputs("mid_reset", 0, 0);
        check("mid_reset.ovf", int'(bus.ovf_err), 0);
        check("mid_reset.udf", int'(bus.udf_err), 0);
        bus.front_sensor = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(15);
        check("abandoned_pulse", int'(bus.pcount), 0);

        for (int i = 1; i <= 8; i++) vecs.push_back('{1'b1, 1'b0, 2, (i > 7) ? 7 : i, (i > 7) ? 1 : 0, 0});
        vecs.push_back('{1'b1, 1'b1, 2, 7, 0, 0});
        for (int i = 6; i >= 4; i--) vecs.push_back('{1'b0, 1'b1, 2, i, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 2, 4, 0, 0});
        for (int i = 3; i >= 0; i--) vecs.push_back('{1'b0, 1'b1, 1, i, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1, 0, 0, 1});
        vecs.push_back('{1'b1, 1'b1, 1, 0, 0, 0});

        foreach (vecs[v]) begin
            bus.tcount = 2'(vecs[v].tc);
            ovf_seen = 0;
            udf_seen = 0;
            pulse(vecs[v].f, vecs[v].r, 10, 10);
            check_outputs($sformatf("vec%0d", v), vecs[v].p, vecs[v].tc);
            check($sformatf("vec%0d.ovf_cycles", v), ovf_seen, vecs[v].ovf);
            check($sformatf("vec%0d.udf_cycles", v), udf_seen, vecs[v].udf);
        end

        // Sensor held high across reset release counts once after full latency.
        bus.front_sensor = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(2);
        check("hold_reset.in_reset", int'(bus.pcount), 0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check($sformatf("hold_reset.k+%0d", i), int'(bus.pcount), (i == 6) ? 1 : 0);
        end
        tick(50);
        check("hold_reset.final", int'(bus.pcount), 1);
        bus.front_sensor = 1'b0;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
